spi_autoread_feeder: RTL
========================

// Module: spi_autoread_feeder
// PURPOSE
//  Byte source for the spi_readout write-FIFO port, sitting between the host SPI write FIFO and spi_readout.
//  Passes host command bytes through unchanged.
//  While the AstroPix interrupt (active-low) is asserted, it injects bursts of idle bytes so the
//  SPI master keeps clocking out hit data without host traffic.
//  The host write FIFO has priority at every byte boundary.
// PARAMETERS
//  IDLE_BYTE     8'h00  byte value injected during an auto burst
//  BURST_BYTES   16     idle bytes per burst (1..255)
//  HOLDOFF_CYC   64     cycles after a burst before the interrupt is re-sampled (>=1)
//  CNT_W         16     width of the burst statistics counter
// PORTS
//  clock            in   1   system clock
//  reset            in   1   synchronous reset, active-high
//  enable           in   1   1 = auto-read enabled; 0 = pure host passthrough
//  interrupt        in   1   AstroPix interrupt pin, asynchronous, active-low
//  host_dout        in   8   host FIFO data (first-word-fall-through)
//  host_empty       in   1   host FIFO empty
//  host_rd_en       out  1   host FIFO pop
//  out_dout         out  8   byte presented to spi_readout
//  out_empty        out  1   0 = out_dout valid
//  out_rd_en        in   1   pop from spi_readout
//  busy             out  1   1 while in AUTO or HOLDOFF
//  burst_count      out  CNT_W  completed auto bursts (only with FEEDER_STATS_EN, else tied 0)
// BEHAVIOUR
//  Clock and reset
//   - One clock; reset is synchronous and active-high. All outputs reset to 0, except out_empty, which resets to 1.
//   - Interrupt path: 2-flop synchroniser, then int_act = ~sync. Reset value of sync is 1 (inactive).
//  Output stage
//   - Single register stage (out_dout, out_valid); out_empty = ~out_valid.
//   - A pop with out_valid=0 is ignored.
//   - The register is loaded when it is empty, or on the same cycle it is popped (zero-bubble).
//  Load source, decided per load
//   - Host first: host_empty=0 -> host_rd_en=1 for one cycle; load host_dout.
//   - Otherwise, in AUTO with burst_left>0 -> load IDLE_BYTE; burst_left--.
//   - Byte latency: host byte to out_dout = 1 cycle.
//  FSM states: IDLE, AUTO, HOLDOFF
//   - IDLE -> AUTO when enable & int_act. Load burst_left = BURST_BYTES.
//   - AUTO -> HOLDOFF when burst_left==0 and the last idle byte has been popped (out_valid=0 or popping).
//     Load hold_cnt = HOLDOFF_CYC.
//   - HOLDOFF counts down to 0.
//     - At 0: int_act -> AUTO (new burst).
//     - At 0: otherwise -> IDLE.
//  Boundary conditions
//   - Host bytes arriving during AUTO interleave at byte granularity. They do not consume burst_left.
//   - enable deasserted in AUTO: finish the byte already in the output register, inject no further idle
//     bytes, go to IDLE. No HOLDOFF and no burst_count increment.
//   - Interrupt deasserting mid-burst does not shorten the burst.
//   - reset mid-burst: immediate IDLE, output register cleared. A host byte already popped is lost
//     (documented).
//   - Simultaneous host byte and idle byte in the same cycle: the host byte wins; the idle byte follows
//     on the next load.
// CONFIGURATION
//  FEEDER_STATS_EN defined
//   - burst_count increments on each AUTO -> HOLDOFF transition.
//   - Wraps modulo 2^CNT_W; cleared by reset.
//  FEEDER_STATS_EN undefined
//   - No counter logic; burst_count = 0.
// STRUCTURE
//  Shared package spi_feeder_pkg
//   - State encoding: IDLE=2'd0, AUTO=2'd1, HOLDOFF=2'd2.
//   - Default IDLE_BYTE constant.
//  Sub-module feeder_sync2: 2-flop synchroniser with a reset value parameter. Also reused by other
//  interrupt consumers.
//  FSM, counters and output register live in the top module.
// TESTING
//  1. Host only, enable=0: push A5,3C; pop each cycle -> out_dout A5 then 3C, 1 cycle latency;
//     out_empty=1 afterwards.
//  2. interrupt low, enable=1, BURST_BYTES=4: continuous pop -> exactly 4x 00, then HOLDOFF for 64
//     cycles with out_empty=1.
//  3. interrupt held low through HOLDOFF -> second burst of 4x 00 starts at hold_cnt=0;
//     burst_count=2 (stats build).
//  4. Host byte 7E pushed after the 2nd idle byte of a burst -> sequence 00,00,7E,00,00;
//     burst_left unaffected.
//  5. enable dropped after the 1st idle byte -> no further 00; state IDLE; burst_count unchanged.
//  6. reset asserted mid-burst with out_valid=1 -> next cycle out_empty=1, busy=0, host_rd_en=0.

Source files
------------

// File: rtl/spi_feeder_pkg.sv
// Shared types and constants for the SPI auto-read feeder and related interrupt consumers.
package spi_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        AUTO    = 2'd1,
        HOLDOFF = 2'd2
    } feeder_state_e;

    localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/spi_autoread_feeder_if.sv
// Byte handshake bundle: host FWFT FIFO read side plus the FIFO-style port toward spi_readout.
interface spi_autoread_feeder_if;
    logic [7:0] host_dout;
    logic       host_empty;
    logic       host_rd_en;
    logic [7:0] out_dout;
    logic       out_empty;
    logic       out_rd_en;

    modport slave (
        input  host_dout, host_empty, out_rd_en,
        output host_rd_en, out_dout, out_empty
    );

    modport master (
        output host_dout, host_empty, out_rd_en,
        input  host_rd_en, out_dout, out_empty
    );
endinterface

// File: rtl/feeder_sync2.sv
// Two-flop synchroniser for asynchronous level inputs; RST_VAL selects the reset level.
module feeder_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);
    logic [1:0] r_sync;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= {2{RST_VAL}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];
endmodule

// File: rtl/spi_autoread_feeder.sv
// Feeds spi_readout with host bytes, injecting idle-byte bursts while the interrupt is active.
// Optional FEEDER_STATS_EN adds a completed-burst counter on burst_count.
module spi_autoread_feeder
    import spi_feeder_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE   = DEFAULT_IDLE_BYTE,
    parameter int         BURST_BYTES = 16,
    parameter int         HOLDOFF_CYC = 64,
    parameter int         CNT_W       = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  interrupt,
    spi_autoread_feeder_if.slave  bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      burst_count
);
    localparam int HOLD_W = $clog2(HOLDOFF_CYC + 1);

    feeder_state_e     r_state;
    feeder_state_e     w_state_nxt;
    logic [7:0]        r_burst_left;
    logic [7:0]        w_burst_left_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;
    logic [7:0]        r_out_dout;
    logic              r_out_valid;
    logic              w_int_sync;
    logic              w_int_act;
    logic              w_pop;
    logic              w_can_load;
    logic              w_host_take;
    logic              w_idle_take;
    logic              w_burst_done;

    feeder_sync2 #(.RST_VAL(1'b1)) u_int_sync (
        .clock (clock),
        .reset (reset),
        .i_d   (interrupt),
        .o_q   (w_int_sync)
    );

    assign w_int_act  = ~w_int_sync;
    assign w_pop      = r_out_valid & bus.out_rd_en;
    assign w_can_load = ~r_out_valid | bus.out_rd_en;
    // Host pop is suppressed during reset so no byte leaves the FIFO while the stage is cleared.
    assign w_host_take = w_can_load & ~bus.host_empty & ~reset;
    assign w_idle_take = w_can_load & bus.host_empty & enable &
                         (r_state == AUTO) & (r_burst_left != 8'd0);

    assign bus.host_rd_en = w_host_take;
    assign bus.out_dout   = r_out_dout;
    assign bus.out_empty  = ~r_out_valid;
    assign busy           = (r_state != IDLE);

    // State, burst and holdoff counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_burst_left <= 8'd0;
            r_hold_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_burst_left <= w_burst_left_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
        end
    end

    // Next-state logic: burst start, burst completion, holdoff countdown.
    always_comb begin
        w_state_nxt      = r_state;
        w_burst_left_nxt = r_burst_left;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_burst_done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && w_int_act) begin
                    w_state_nxt      = AUTO;
                    w_burst_left_nxt = 8'(BURST_BYTES);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            AUTO: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end else if ((r_burst_left == 8'd0) && (!r_out_valid || w_pop)) begin
                    w_state_nxt    = HOLDOFF;
                    w_hold_cnt_nxt = HOLD_W'(HOLDOFF_CYC);
                    w_burst_done   = 1'b1;
                end else if (w_idle_take) begin
                    w_burst_left_nxt = r_burst_left - 8'd1;
                end else begin
                    w_state_nxt = AUTO;
                end
            end
            HOLDOFF: begin
                if (r_hold_cnt != '0) begin
                    w_hold_cnt_nxt = r_hold_cnt - HOLD_W'(1);
                end else if (enable && w_int_act) begin
                    w_state_nxt      = AUTO;
                    w_burst_left_nxt = 8'(BURST_BYTES);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output stage: host byte wins; reload on the cycle of a pop for zero-bubble streaming.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_dout  <= 8'h00;
            r_out_valid <= 1'b0;
        end else if (w_host_take) begin
            r_out_dout  <= bus.host_dout;
            r_out_valid <= 1'b1;
        end else if (w_idle_take) begin
            r_out_dout  <= IDLE_BYTE;
            r_out_valid <= 1'b1;
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

`ifdef FEEDER_STATS_EN
    logic [CNT_W-1:0] r_burst_count;

    // Completed-burst counter, wraps naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_burst_count <= '0;
        end else if (w_burst_done) begin
            r_burst_count <= r_burst_count + CNT_W'(1);
        end else begin
            r_burst_count <= r_burst_count;
        end
    end

    assign burst_count = r_burst_count;
`else
    logic w_unused_burst_done;
    assign w_unused_burst_done = w_burst_done;
    assign burst_count         = {CNT_W{1'b0}};
`endif

endmodule
